// File: rtl/bcd_down_timer_if.sv
// bcd_down_timer_if: load/control inputs and count/status outputs of the BCD down timer
interface bcd_down_timer_if;
  logic       ldn;
  logic [7:0] data_in;
  logic       start;
  logic       pause;
  logic       tick;
  logic [7:0] q_out;
  logic       bo;
  logic       done;
  logic [1:0] state_out;
  modport master (output ldn, data_in, start, pause, tick, input q_out, bo, done, state_out);
  modport slave (input ldn, data_in, start, pause, tick, output q_out, bo, done, state_out);
endinterface

// File: rtl/bcd_down_timer.sv
// bcd_down_timer: two-digit BCD down counter with prescaler and IDLE/RUN/PAUSE/DONE FSM
// Optional BCD_DOWN_TIMER_AUTO_RELOAD_EN: DONE lasts one cycle, then reloads and resumes RUN.
module bcd_down_timer #(
  parameter int TICK_DIV = 1
) (
  input logic clk,
  input logic clrn,
  bcd_down_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
  state_t state, state_nx;
  logic [7:0] q, q_nx, ld_val, dec;
  logic [3:0] psc, psc_nx;
  logic done_r, done_nx, step;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
  logic [7:0] reload;
`endif
  assign ld_val = {bus.data_in[7:4] > 4'd9 ? 4'd9 : bus.data_in[7:4],
                   bus.data_in[3:0] > 4'd9 ? 4'd9 : bus.data_in[3:0]};
  assign dec = q[3:0] == 4'd0 ? {q[7:4] - 4'd1, 4'd9} : {q[7:4], q[3:0] - 4'd1};
  assign step = psc == 4'(TICK_DIV - 1);
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state <= IDLE;
      q <= 8'h00;
      psc <= 4'd0;
      done_r <= 1'b0;
    end else begin
      state <= state_nx;
      q <= q_nx;
      psc <= psc_nx;
      done_r <= done_nx;
    end
  end
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
  always_ff @(posedge clk) begin
    if (!clrn) reload <= 8'h00;
    else if (!bus.ldn) reload <= ld_val;
  end
`endif
  // priority: load, then pause, then start, then count
  always_comb begin
    state_nx = state;
    q_nx = q;
    psc_nx = psc;
    done_nx = 1'b0;
    if (!bus.ldn) begin
      state_nx = IDLE;
      q_nx = ld_val;
      psc_nx = 4'd0;
    end else begin
      case (state)
        IDLE: if (!bus.pause && bus.start) begin
          state_nx = q == 8'h00 ? DONE : RUN;
          done_nx = q == 8'h00;
        end
        RUN: if (bus.pause) state_nx = PAUSE;
        else if (bus.tick) begin
          psc_nx = step ? 4'd0 : psc + 4'd1;
          if (step) begin
            q_nx = dec;
            state_nx = dec == 8'h00 ? DONE : RUN;
            done_nx = dec == 8'h00;
          end
        end
        PAUSE: if (!bus.pause && bus.start) state_nx = RUN;
        DONE: begin
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
          if (reload != 8'h00) begin
            state_nx = RUN;
            q_nx = reload;
            psc_nx = 4'd0;
          end
`endif
        end
      endcase
    end
  end
  always_comb begin
    bus.q_out = q;
    bus.done = done_r;
    bus.state_out = state;
    bus.bo = state == RUN && q == 8'h00 && bus.tick;
  end
endmodule

// File: tb/tb_bcd_down_timer.sv
// tb_bcd_down_timer: directed checks of load, clamp, borrow, prescale, pause, reset and reload
module tb_bcd_down_timer;
  logic clk = 1'b0;
  logic clrn;
  int errs = 0;
  int checks = 0;
  int pulses;
  bcd_down_timer_if a ();
  bcd_down_timer_if b ();
  bcd_down_timer #(.TICK_DIV(1)) u1 (.clk(clk), .clrn(clrn), .bus(a.slave));
  bcd_down_timer #(.TICK_DIV(3)) u3 (.clk(clk), .clrn(clrn), .bus(b.slave));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    clrn = 1'b0;
    a.tick = 1'b1;
    cyc();
    checks++; if (a.q_out !== 8'h00) begin errs++; $display("FAIL rst_q got %h want 00", a.q_out); end
    checks++; if (a.state_out !== 2'd0) begin errs++; $display("FAIL rst_state got %0d want 0", a.state_out); end
    checks++; if (a.done !== 1'b0) begin errs++; $display("FAIL rst_done got %b want 0", a.done); end
    checks++; if (a.bo !== 1'b0) begin errs++; $display("FAIL idle_bo got %b want 0", a.bo); end
    checks++; if (b.q_out !== 8'h00) begin errs++; $display("FAIL rst_q_b got %h want 00", b.q_out); end
    clrn = 1'b1; a.tick = 1'b0;
    a.ldn = 1'b0; a.data_in = 8'h42;
    cyc();
    a.ldn = 1'b1; a.start = 1'b1;
    cyc();
    a.start = 1'b0;
    checks++; if (a.state_out !== 2'd1 || a.q_out !== 8'h42) begin errs++; $display("FAIL run42 got %0d/%h want 1/42", a.state_out, a.q_out); end
    clrn = 1'b0; a.ldn = 1'b0; a.start = 1'b1; a.tick = 1'b1; a.data_in = 8'h77;
    cyc();
    checks++; if (a.q_out !== 8'h00 || a.state_out !== 2'd0 || a.done !== 1'b0) begin
      errs++; $display("FAIL midrun_rst got %h/%0d/%b want 00/0/0", a.q_out, a.state_out, a.done); end
    clrn = 1'b1; a.ldn = 1'b1; a.start = 1'b0; a.tick = 1'b0;
  endtask
  task automatic test_borrow();
    logic [7:0] seq [10] = '{8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    a.ldn = 1'b0; a.data_in = 8'h10;
    cyc();
    a.ldn = 1'b1; a.start = 1'b1;
    cyc();
    a.start = 1'b0;
    checks++; if (a.q_out !== 8'h10 || a.state_out !== 2'd1) begin errs++; $display("FAIL borrow_start got %h/%0d want 10/1", a.q_out, a.state_out); end
    a.tick = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (a.done) pulses++;
      checks++; if (a.q_out !== seq[i]) begin errs++; $display("FAIL borrow_q step %0d got %h want %h", i, a.q_out, seq[i]); end
      checks++; if (a.bo !== 1'b0) begin errs++; $display("FAIL borrow_bo step %0d got %b want 0", i, a.bo); end
    end
    checks++; if (a.state_out !== 2'd3 || a.done !== 1'b1) begin errs++; $display("FAIL borrow_done got %0d/%b want 3/1", a.state_out, a.done); end
    a.start = 1'b1; a.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (a.done) pulses++;
`ifndef BCD_DOWN_TIMER_AUTO_RELOAD_EN
      checks++; if (a.state_out !== 2'd3 || a.q_out !== 8'h00 || a.bo !== 1'b0) begin
        errs++; $display("FAIL done_hold %0d got %0d/%h/%b want 3/00/0", i, a.state_out, a.q_out, a.bo); end
`endif
    end
    checks++; if (pulses !== 1) begin errs++; $display("FAIL done_pulses got %0d want 1", pulses); end
    a.start = 1'b0; a.pause = 1'b0; a.tick = 1'b0;
  endtask
  task automatic test_prescale();
    b.ldn = 1'b0; b.data_in = 8'h05;
    cyc();
    b.ldn = 1'b1; b.start = 1'b1;
    cyc();
    b.start = 1'b0; b.tick = 1'b1;
    cyc(); cyc();
    checks++; if (b.q_out !== 8'h05) begin errs++; $display("FAIL pre_two got %h want 05", b.q_out); end
    cyc();
    checks++; if (b.q_out !== 8'h04) begin errs++; $display("FAIL pre_three got %h want 04", b.q_out); end
    b.pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++; if (b.q_out !== 8'h04 || b.state_out !== 2'd2) begin errs++; $display("FAIL pause_hold %0d got %h/%0d want 04/2", i, b.q_out, b.state_out); end
    end
    b.start = 1'b1;
    cyc();
    checks++; if (b.state_out !== 2'd2) begin errs++; $display("FAIL pause_start_both got %0d want 2", b.state_out); end
    b.pause = 1'b0;
    cyc();
    checks++; if (b.state_out !== 2'd1 || b.q_out !== 8'h04) begin errs++; $display("FAIL resume got %0d/%h want 1/04", b.state_out, b.q_out); end
    b.start = 1'b0;
    for (int i = 0; i < 11; i++) cyc();
    checks++; if (b.q_out !== 8'h01 || b.state_out !== 2'd1) begin errs++; $display("FAIL pre_14 got %h/%0d want 01/1", b.q_out, b.state_out); end
    cyc();
    checks++; if (b.q_out !== 8'h00 || b.state_out !== 2'd3 || b.done !== 1'b1) begin
      errs++; $display("FAIL pre_15 got %h/%0d/%b want 00/3/1", b.q_out, b.state_out, b.done); end
    b.tick = 1'b0;
  endtask
  task automatic test_clamp();
    logic [7:0] din [3] = '{8'hAF, 8'hFF, 8'hA7};
    logic [7:0] want [3] = '{8'h99, 8'h99, 8'h97};
    for (int i = 0; i < 3; i++) begin
      a.ldn = 1'b0; a.data_in = din[i];
      cyc();
      checks++; if (a.q_out !== want[i] || a.state_out !== 2'd0) begin errs++; $display("FAIL clamp %h got %h/%0d want %h/0", din[i], a.q_out, a.state_out, want[i]); end
    end
    a.data_in = 8'h00;
    cyc();
    a.ldn = 1'b1; a.start = 1'b1;
    cyc();
    a.start = 1'b0;
    checks++; if (a.state_out !== 2'd3 || a.done !== 1'b1) begin errs++; $display("FAIL zero_start got %0d/%b want 3/1", a.state_out, a.done); end
    cyc();
    checks++; if (a.state_out !== 2'd3 || a.done !== 1'b0) begin errs++; $display("FAIL zero_after got %0d/%b want 3/0", a.state_out, a.done); end
  endtask
  task automatic test_load_priority();
    a.ldn = 1'b0; a.data_in = 8'h42;
    cyc();
    a.ldn = 1'b1; a.start = 1'b1;
    cyc();
    a.start = 1'b0; a.tick = 1'b1;
    cyc(); cyc();
    checks++; if (a.q_out !== 8'h40) begin errs++; $display("FAIL run_q got %h want 40", a.q_out); end
    a.ldn = 1'b0; a.start = 1'b1; a.data_in = 8'h37;
    cyc();
    checks++; if (a.q_out !== 8'h37 || a.state_out !== 2'd0) begin errs++; $display("FAIL load_prio got %h/%0d want 37/0", a.q_out, a.state_out); end
    a.ldn = 1'b1; a.start = 1'b0; a.tick = 1'b0;
  endtask
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    logic [7:0] seq [6] = '{8'h01, 8'h00, 8'h02, 8'h01, 8'h00, 8'h02};
    logic dn [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    a.ldn = 1'b0; a.data_in = 8'h02;
    cyc();
    a.ldn = 1'b1; a.start = 1'b1;
    cyc();
    a.start = 1'b0; a.tick = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++; if (a.q_out !== seq[i] || a.done !== dn[i]) begin errs++; $display("FAIL reload %0d got %h/%b want %h/%b", i, a.q_out, a.done, seq[i], dn[i]); end
    end
    a.tick = 1'b0;
  endtask
`endif
  initial begin
    clrn = 1'b0;
    a.ldn = 1'b1; a.data_in = 8'h00; a.start = 1'b0; a.pause = 1'b0; a.tick = 1'b0;
    b.ldn = 1'b1; b.data_in = 8'h00; b.start = 1'b0; b.pause = 1'b0; b.tick = 1'b0;
    cyc();
    test_reset();
    test_borrow();
    test_prescale();
    test_clamp();
    test_load_priority();
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/bcd_down_timer.md
BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1, meaning the number of qualified tick cycles per decrement (legal range 1..15).
REQ-002 Port clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port clrn, input, 1, SHALL be the reset: synchronous and active-low.
REQ-004 Port ldn, input, 1, SHALL be the active-low synchronous load strobe.
REQ-005 Port data_in, input, 8, SHALL carry the load value: [7:4] tens BCD, [3:0] units BCD.
REQ-006 Port start, input, 1, SHALL request a start or resume of the countdown.
REQ-007 Port pause, input, 1, SHALL request a freeze of the countdown.
REQ-008 Port tick, input, 1, SHALL be the count-enable qualifier (cascade input, like ent).
REQ-009 Port q_out, output, 8, SHALL carry the current count as two BCD digits.
REQ-010 Port bo, output, 1, SHALL be the combinational borrow-out: high when q_out==8'h00 and tick==1 in RUN.
REQ-011 Port done, output, 1, SHALL be a registered one-cycle pulse at expiry.
REQ-012 Port state_out, output, 2, SHALL show the FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, PAUSE and DONE, with one transition evaluated per cycle.
REQ-014 Input priority per edge SHALL be: clrn, then ldn, then pause, then start, then count.
REQ-015 ldn==0 SHALL load data_in into q_out and the reload register, clear the prescaler, and force IDLE, from any state.
REQ-016 A loaded digit greater than 9 SHALL be clamped to 9 per digit (for example 8'hA7 loads 8'h97 and 8'hFF loads 8'h99).
REQ-017 IDLE to RUN SHALL occur on start==1 if q_out!=00; start with q_out==00 SHALL go directly to DONE with a done pulse.
REQ-018 In RUN, each cycle with tick==1 SHALL advance the prescaler, and when it reaches TICK_DIV-1 it SHALL wrap to 0 and decrement q_out.
REQ-019 The decrement SHALL be BCD: units 0 becomes 9 with a borrow to tens; units 1..9 decrement by 1.
REQ-020 The decrement that produces 00 SHALL transition to DONE and assert done on the next cycle, for exactly 1 cycle.
REQ-021 In RUN, pause==1 SHALL go to PAUSE, hold q_out and the prescaler, and ignore tick.
REQ-022 PAUSE to RUN SHALL occur on start==1 with pause==0; simultaneous start and pause SHALL stay in PAUSE.
REQ-023 DONE SHALL hold q_out==00 until ldn or clrn (base build); start and pause SHALL be ignored.
REQ-024 In IDLE and PAUSE, tick SHALL have no effect and bo SHALL be 0.
REQ-025 bo SHALL be combinational from q_out, tick and state so that a higher digit pair can be cascaded, and SHALL never be registered.

Reset
REQ-026 On clrn==0 at a clock edge: q_out=8'h00, reload register=8'h00, prescaler=0, state=IDLE, done=0.
REQ-027 clrn SHALL override ldn, start and tick in the same cycle, including mid-RUN and mid-PAUSE.
REQ-028 No output SHALL change asynchronously on clrn.

Configuration
REQ-029 Macro BCD_DOWN_TIMER_AUTO_RELOAD_EN, when defined, SHALL make DONE last exactly 1 cycle (done pulsed); q_out SHALL then be restored from the reload register and the FSM SHALL return to RUN, with the prescaler cleared.
REQ-030 With the macro defined and a reload value of 00, the FSM SHALL stay in DONE (no reload loop).
REQ-031 Without the macro, the behaviour SHALL be exactly REQ-023, and the reload register MAY be optimised away.

Verification
REQ-032 Reset: clrn=0 for 1 cycle during RUN at 8'h42 -> q_out=00, state_out=0, done=0 the next cycle.
REQ-033 Borrow: load 8'h10, start, TICK_DIV=1, tick=1 -> q_out 10,09,08...01,00; DONE; done pulses once; bo=1 only in the cycle q_out==00 in RUN (zero cycles here, since the state leaves RUN).
REQ-034 Prescale/pause: TICK_DIV=3, load 8'h05, start, tick=1, pause at cycle 4 for 5 cycles, then start -> q_out 04 after 3 ticks, held during PAUSE, reaches 00 after 15 qualified ticks.
REQ-035 Clamp/edge: load 8'hAF -> q_out=8'h99; start with 8'h00 loaded -> DONE and done=1 the next cycle.
REQ-036 Load priority: ldn=0 and start=1 in the same cycle while in RUN -> q_out=data_in, state IDLE.
REQ-037 Auto-reload (macro defined): load 8'h02, start, tick=1 -> q_out sequence 02,01,00,02,01,00...; done pulses every third count.
